// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized input, mid-bit sampling, one-cycle
// DV / frame-error pulses and a busy flag.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t        r_State;
    state_t        w_Next;
    logic          r_Sync1;
    logic          r_Sync2;
    logic          r_Prev;
    logic          r_Fall;
    logic [CW-1:0] r_Cnt;
    logic [CW-1:0] w_Cnt;
    logic [2:0]    r_Idx;
    logic [2:0]    w_Idx;
    logic [7:0]    r_Shift;
    logic [7:0]    w_Shift;
    logic [7:0]    r_Byte;
    logic [7:0]    w_Byte;
    logic          r_DV;
    logic          w_DV;
    logic          r_FE;
    logic          w_FE;
    logic          r_Active;
    logic          w_Line;
    logic          w_Fall;

    assign w_Line = r_Sync2;
    assign w_Fall = r_Prev & ~w_Line;

    // Edge is registered only while idle so mid-frame edges never start a frame
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
            r_Prev  <= 1'b1;
            r_Fall  <= 1'b0;
        end else begin
            r_Sync1 <= i_Rx_Serial;
            r_Sync2 <= r_Sync1;
            r_Prev  <= w_Line;
            r_Fall  <= w_Fall && (r_State == IDLE) && !r_Fall;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State  <= IDLE;
            r_Cnt    <= '0;
            r_Idx    <= '0;
            r_Shift  <= '0;
            r_Byte   <= '0;
            r_DV     <= 1'b0;
            r_FE     <= 1'b0;
            r_Active <= 1'b0;
        end else begin
            r_State  <= w_Next;
            r_Cnt    <= w_Cnt;
            r_Idx    <= w_Idx;
            r_Shift  <= w_Shift;
            r_Byte   <= w_Byte;
            r_DV     <= w_DV;
            r_FE     <= w_FE;
            r_Active <= (w_Next != IDLE);
        end
    end

    always_comb begin
        w_Next  = r_State;
        w_Cnt   = r_Cnt;
        w_Idx   = r_Idx;
        w_Shift = r_Shift;
        w_Byte  = r_Byte;
        w_DV    = 1'b0;
        w_FE    = 1'b0;
        case (r_State)
            IDLE: begin
                w_Cnt = '0;
                w_Idx = '0;
                if (r_Fall) begin
                    w_Next = START;
                end
            end
            START: begin
                if (r_Cnt == HALF) begin
                    w_Cnt  = '0;
                    w_Next = w_Line ? IDLE : DATA;
                end else begin
                    w_Cnt = r_Cnt + CW'(1);
                end
            end
            DATA: begin
                if (r_Cnt == LAST) begin
                    w_Cnt          = '0;
                    w_Shift[r_Idx] = w_Line;
                    if (r_Idx == 3'd7) begin
                        w_Idx  = '0;
                        w_Next = STOP;
                    end else begin
                        w_Idx = r_Idx + 3'd1;
                    end
                end else begin
                    w_Cnt = r_Cnt + CW'(1);
                end
            end
            STOP: begin
                if (r_Cnt == LAST) begin
                    w_Cnt  = '0;
                    w_Next = CLEANUP;
                    if (w_Line) begin
                        w_Byte = r_Shift;
                        w_DV   = 1'b1;
                    end else begin
                        w_FE = 1'b1;
                    end
                end else begin
                    w_Cnt = r_Cnt + CW'(1);
                end
            end
            CLEANUP: begin
                w_Cnt  = '0;
                w_Idx  = '0;
                w_Next = IDLE;
            end
            default: begin
                w_Cnt  = '0;
                w_Idx  = '0;
                w_Next = IDLE;
            end
        endcase
    end

    assign o_Rx_DV        = r_DV;
    assign o_Rx_Byte      = r_Byte;
    assign o_Rx_Frame_Err = r_FE;
    assign o_Rx_Active    = r_Active;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: stimulus pushes
// expected DV / frame-error events, a negedge monitor pops and compares.
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = (C - 1) / 2;
    // two synchronizer stages ahead of the edge-to-DV latency
    localparam int LAT = 2 + H + 9 * C + 3;

    typedef struct {
        bit         fe;
        logic [7:0] b;
        bit         timed;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv;
    logic [7:0] rbyte;
    logic       fe;
    logic       act;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_byte = 8'h00;
    exp_t       q[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rbyte),
        .o_Rx_Frame_Err (fe),
        .o_Rx_Active    (act)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv && fe) begin
                checks++;
                failures++;
                $display("FAIL dv_fe_both actual=1 expected=0");
            end
            if (dv || fe) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse dv=%0b fe=%0b byte=%0h", dv, fe, rbyte);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk(e.fe ? "fe_pulse" : "dv_pulse", {31'd0, fe}, {31'd0, e.fe});
                    chk("byte", {24'd0, rbyte}, {24'd0, e.b});
                    if (e.timed) chk("latency", cyc - e.t, LAT);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit timed);
        exp_t e;
        e.fe    = !stop_bit;
        e.b     = stop_bit ? b : model_byte;
        e.timed = timed;
        e.t     = cyc;
        if (stop_bit) model_byte = b;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 4 * C) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv", {31'd0, dv}, 0);
        chk("rst_fe", {31'd0, fe}, 0);
        chk("rst_active", {31'd0, act}, 0);
        chk("rst_byte", {24'd0, rbyte}, 0);
        rst_n = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b1, 1'b1);
        drain("drain_a5");
        repeat (C) @(posedge clk);
        #1;

        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_active_hi", {31'd0, act}, 1);
        repeat (3 * C) @(posedge clk);
        #1;
        chk("glitch_active_lo", {31'd0, act}, 0);
        chk("glitch_byte", {24'd0, rbyte}, {24'd0, model_byte});

        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b1;
        drain("drain_3c");
        repeat (2 * C) @(posedge clk);
        #1;

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drain("drain_b2b");
        repeat (2 * C) @(posedge clk);
        #1;

        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (C / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_byte = 8'h00;
        #20;
        rx = 1'b1;
        #20;
        rst_n = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        chk("abort_byte", {24'd0, rbyte}, 0);
        chk("abort_active", {31'd0, act}, 0);
        send_frame(8'h42, 1'b1, 1'b1);
        drain("drain_42");
        repeat (2 * C) @(posedge clk);
        #1;

        begin
            exp_t e;
            e.fe    = 1'b1;
            e.b     = model_byte;
            e.timed = 1'b1;
            e.t     = cyc;
            q.push_back(e);
        end
        rx = 1'b0;
        repeat (30 * C) @(posedge clk);
        #1;
        chk("break_queue", q.size(), 0);
        chk("break_active", {31'd0, act}, 0);
        chk("break_byte", {24'd0, rbyte}, 8'h42);
        q.delete();
        rx = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        chk("break_idle_active", {31'd0, act}, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        drain("drain_5a");
        repeat (C) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
